alu_exec_stage: RTL and testbench
=================================

Name: alu_exec_stage

Overview:
Execute-stage wrapper directly upstream and downstream of the 32-bit ALU. It accepts decoded ALU operations over a valid/ready handshake and registers the operands. It drives the ALU's A/B/control inputs from that register, captures the ALU result and carry, and derives flags. Results go into a 2-entry output buffer that feeds writeback over a second valid/ready handshake, so writeback stalls never corrupt in-flight results.

Parameters:
DATA_W, 32, operand/result width; must match the ALU data width.
TAG_W, 5, destination-register tag width carried alongside each operation.
CNT_W, 16, width of the retired-operation counter.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream operation valid
in_ready  output  1  stage can accept an operation this cycle
in_op  input  3  ALU op: 000 NOT A, 001 AND, 010 arith SHR A by B, 011 XOR, 100 ADD, 101 SUB, 110/111 illegal
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_tag  input  TAG_W  destination tag
alu_a  output  DATA_W  to ALU input A
alu_b  output  DATA_W  to ALU input B
alu_ctrl  output  3  to ALU control
alu_dout  input  DATA_W  from ALU data out (combinational from alu_a/alu_b/alu_ctrl)
alu_cout  input  1  from ALU carry out
out_valid  output  1  result available at buffer head
out_ready  input  1  writeback accepts result
out_data  output  DATA_W  result
out_tag  output  TAG_W  destination tag of result
out_carry  output  1  carry flag
out_zero  output  1  result == 0
out_neg  output  1  result MSB
out_illegal  output  1  op was 110/111
op_count  output  CNT_W  number of results popped since reset

Behaviour:
- Reset (rst_n low, async): operand register invalid (op_valid=0). Operand/op/tag registers = 0. Buffer empty (count=0, pointers 0). Buffer storage contents don't-care; out_* data fields read 0 while empty. out_valid=0, in_ready=0 while rst_n low, op_count=0, alu_a/alu_b/alu_ctrl=0.
- Stage 1 (operand register): loads in_op/in_a/in_b/in_tag on edge where in_valid && in_ready. Otherwise holds. alu_a/alu_b/alu_ctrl are driven directly from this register.
- buf_space = (count < 2) || (out_valid && out_ready).
- in_ready = rst_n && (!op_valid || buf_space). This is combinational; in_valid must not depend on in_ready.
- Stage 2 (push): on edge where op_valid && buf_space, push {data, tag, carry, zero, neg, illegal} into the buffer. op_valid then becomes 1 if a new op is accepted the same edge, else 0.
- Push fields:
  - Legal op: data = alu_dout.
  - carry = alu_cout for 100/101, 0 for 000–011.
  - zero = (data == 0); neg = data[DATA_W-1].
  - Illegal op (110/111): data=0, carry=0, zero=0, neg=0, illegal=1. Counts as a normal result.
- Latency: accepted at edge N -> out_valid=1 after edge N+1 if buffer was empty. Throughput is 1 op/cycle with out_ready held 1.
- Buffer: 2-entry circular FIFO, in order. Simultaneous push and pop at count=2 is legal and leaves count=2. Push at count=2 without pop never occurs. Pop when out_valid && out_ready. out_valid = (count != 0). Head fields are held stable while out_valid && !out_ready.
- op_count increments on each pop and wraps 2^CNT_W-1 -> 0.
- Max occupancy: 3 ops (1 operand register + 2 buffer) before in_ready drops.
- Reset mid-operation discards the operand register and all buffered results; no partial output.

Test Plan:
- ADD: A=0xFFFFFFFF, B=0x00000001, out_ready=1 -> one cycle after accept: data=0x00000000, carry=1, zero=1, neg=0, tag echoed; op_count=1 after pop.
- SUB and shift: SUB A=5, B=7 -> data=0xFFFFFFFE, neg=1, zero=0. SHR A=0x80000000, B=4 -> data=0xF8000000, carry=0.
- Back-pressure: out_ready=0, issue 4 ops with tags 1,2,3,4 -> first 3 accepted, in_ready=0 on 4th, head tag=1 stable. Raise out_ready -> tags pop 1,2,3,4 in order, no loss or duplicate.
- Full push+pop: count=2 with op_valid, out_ready=1 every cycle and a continuous stream of 10 ops -> in_ready stays 1, one result/cycle, op_count=10.
- Illegal op: in_op=110, A=B=0x12345678 -> data=0, illegal=1, flags 0, op_count increments.
- Async reset: assert rst_n=0 mid-cycle with 3 ops in flight -> out_valid, in_ready, op_count go to 0 immediately. After release, the first new op returns a correct result with no stale entries.

Source files
------------

// File: rtl/alu_exec_stage_if.sv
// Valid/ready handshake bundle for the ALU execute stage: the operation request side
// (in_*) and the result/writeback side (out_*).
interface alu_exec_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              out_carry;
  logic              out_zero;
  logic              out_neg;
  logic              out_illegal;

  // Environment side: issues operations and consumes results.
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_neg, out_illegal
  );

  // Execute stage side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_neg, out_illegal
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage around an external 32-bit ALU: one operand register feeding the ALU and a
// 2-entry in-order result buffer that decouples writeback stalls from the pipeline.
module alu_exec_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_stage_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_dout,
  input  logic              alu_cout,
  output logic [CNT_W-1:0]  op_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic              carry;
    logic              zero;
    logic              neg;
    logic              illegal;
  } entry_t;

  // Operand register
  logic              op_valid_q, op_valid_d;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [TAG_W-1:0]  tag_q;

  // Result buffer
  entry_t     buf_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic [CNT_W-1:0] op_count_q;

  logic   pop, push, accept, buf_space, out_valid;
  logic   illegal, is_arith;
  entry_t push_entry, head;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && bus.out_ready;
  assign buf_space = (count_q < 2'd2) || pop;
  assign bus.in_ready = rst_n && (!op_valid_q || buf_space);
  assign accept    = bus.in_valid && bus.in_ready;
  assign push      = op_valid_q && buf_space;

  assign illegal  = op_q[2] & op_q[1];
  assign is_arith = op_q[2] & ~op_q[1];

  always_comb begin
    push_entry         = '0;
    push_entry.tag     = tag_q;
    push_entry.illegal = illegal;
    if (!illegal) begin
      push_entry.data  = alu_dout;
      // The ALU's carry output is only meaningful for ADD/SUB.
      push_entry.carry = is_arith & alu_cout;
      push_entry.zero  = (alu_dout == '0);
      push_entry.neg   = alu_dout[DATA_W-1];
    end
  end

  always_comb begin
    op_valid_d = op_valid_q;
    if (accept)    op_valid_d = 1'b1;
    else if (push) op_valid_d = 1'b0;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      op_count_q <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      if (accept) begin
        op_q  <= bus.in_op;
        a_q   <= bus.in_a;
        b_q   <= bus.in_b;
        tag_q <= bus.in_tag;
      end
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q   <= ~rd_ptr_q;
        op_count_q <= op_count_q + CNT_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage contents are don't-care after reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= push_entry;
  end

  assign head = out_valid ? buf_q[rd_ptr_q] : '0;

  assign bus.out_valid   = out_valid;
  assign bus.out_data    = head.data;
  assign bus.out_tag     = head.tag;
  assign bus.out_carry   = head.carry;
  assign bus.out_zero    = head.zero;
  assign bus.out_neg     = head.neg;
  assign bus.out_illegal = head.illegal;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_ctrl = op_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural ALU hooked to the alu_* ports.
module tb_alu_exec_stage;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned CNT_W  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [DATA_W-1:0] alu_a, alu_b, alu_dout;
  logic [2:0]        alu_ctrl;
  logic              alu_cout;
  logic [CNT_W-1:0]  op_count;

  int n_vec = 0;
  int n_bad = 0;
  logic [CNT_W-1:0] exp_cnt;

  alu_exec_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  alu_exec_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_dout (alu_dout),
    .alu_cout (alu_cout),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; carry and data are deliberately junk where the stage must mask them.
  always_comb begin
    alu_dout = '0;
    alu_cout = 1'b1;
    case (alu_ctrl)
      3'b000:  alu_dout = ~alu_a;
      3'b001:  alu_dout = alu_a & alu_b;
      3'b010:  alu_dout = $signed(alu_a) >>> alu_b[4:0];
      3'b011:  alu_dout = alu_a ^ alu_b;
      3'b100:  {alu_cout, alu_dout} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b101:  {alu_cout, alu_dout} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      default: alu_dout = alu_a ^ 32'hDEAD_BEEF;
    endcase
  end

  // {valid, data, tag, carry, zero, neg, illegal}
  function automatic logic [41:0] head();
    return {bus.out_valid, bus.out_data, bus.out_tag, bus.out_carry, bus.out_zero,
            bus.out_neg, bus.out_illegal};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic valid);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    bus.in_valid = valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(3'b000, '0, '0, '0, 1'b0);
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    n_vec++;
    if (head() !== 42'd0) begin
      n_bad++; $display("FAIL reset_head: got %h want %h", head(), 42'd0);
    end
    n_vec++;
    if (bus.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    n_vec++;
    if (op_count !== 16'd0) begin
      n_bad++; $display("FAIL reset_op_count: got %0d want 0", op_count);
    end
    n_vec++;
    if ({alu_ctrl, alu_a, alu_b} !== 67'd0) begin
      n_bad++; $display("FAIL reset_alu_bus: got %h want 0", {alu_ctrl, alu_a, alu_b});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL post_reset_ready: got %b want 10", {bus.in_ready, bus.out_valid});
    end
    exp_cnt = '0;
  endtask

  task automatic test_add();
    @(negedge clk);
    drive(3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 5'h0A, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL add_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_vec++;
    if ({alu_ctrl, alu_a, alu_b} !== {3'b100, 32'hFFFF_FFFF, 32'h0000_0001}) begin
      n_bad++; $display("FAIL add_alu_bus: got %h want %h", {alu_ctrl, alu_a, alu_b},
                        {3'b100, 32'hFFFF_FFFF, 32'h0000_0001});
    end
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL add_early_valid: got %b want 0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (head() !== {1'b1, 32'h0, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL add_result: got %h want %h", head(),
                        {1'b1, 32'h0, 5'h0A, 1'b1, 1'b1, 1'b0, 1'b0});
    end
    exp_cnt++;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, op_count} !== {1'b0, exp_cnt}) begin
      n_bad++; $display("FAIL add_pop: got %h want %h", {bus.out_valid, op_count},
                        {1'b0, exp_cnt});
    end
  endtask

  task automatic test_alu_ops();
    logic [2:0]  vop [5] = '{3'b101, 3'b010, 3'b000, 3'b001, 3'b011};
    logic [31:0] va  [5] = '{32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFF00_FF00, 32'h7FFF_FFFF};
    logic [31:0] vb  [5] = '{32'd7, 32'd4, 32'h0000_1234, 32'h0FF0_0FF0, 32'hFFFF_FFFF};
    logic [31:0] vd  [5] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'h0, 32'h0F00_0F00, 32'h8000_0000};
    logic [2:0]  vf  [5] = '{3'b001, 3'b001, 3'b010, 3'b000, 3'b001}; // {carry, zero, neg}
    logic [41:0] exp;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(vop[i], va[i], vb[i], 5'(i + 1), 1'b1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      exp = {1'b1, vd[i], 5'(i + 1), vf[i], 1'b0};
      n_vec++;
      if (head() !== exp) begin
        n_bad++; $display("FAIL alu_op_%0d: got %h want %h", i, head(), exp);
      end
      exp_cnt++;
    end
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, op_count} !== {1'b0, exp_cnt}) begin
      n_bad++; $display("FAIL alu_ops_count: got %h want %h", {bus.out_valid, op_count},
                        {1'b0, exp_cnt});
    end
  endtask

  task automatic test_illegal();
    logic [41:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(3'b110 + 3'(i), 32'h1234_5678, 32'h1234_5678, 5'(20 + i), 1'b1);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      exp = {1'b1, 32'h0, 5'(20 + i), 1'b0, 1'b0, 1'b0, 1'b1};
      n_vec++;
      if (head() !== exp) begin
        n_bad++; $display("FAIL illegal_%0d: got %h want %h", i, head(), exp);
      end
      exp_cnt++;
      @(negedge clk);
      #1;
      n_vec++;
      if (op_count !== exp_cnt) begin
        n_bad++; $display("FAIL illegal_count_%0d: got %0d want %0d", i, op_count, exp_cnt);
      end
    end
  endtask

  task automatic test_backpressure();
    int  got = 0;
    logic acc;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(3'b100, 32'(i + 1), 32'd0, 5'(i + 1), 1'b1);
      #1;
      n_vec++;
      if (bus.in_ready !== (i < 3)) begin
        n_bad++; $display("FAIL bp_in_ready_%0d: got %b want %b", i, bus.in_ready, (i < 3));
      end
    end
    repeat (2) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({bus.out_valid, bus.out_tag, bus.out_data, bus.in_ready} !== {1'b1, 5'd1, 32'd1, 1'b0})
      begin
        n_bad++; $display("FAIL bp_head_stable: got %h want %h",
                          {bus.out_valid, bus.out_tag, bus.out_data, bus.in_ready},
                          {1'b1, 5'd1, 32'd1, 1'b0});
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      if (bus.out_valid) begin
        n_vec++;
        if ({bus.out_tag, bus.out_data} !== {5'(got + 1), 32'(got + 1)}) begin
          n_bad++; $display("FAIL bp_order_%0d: got %h want %h", got,
                            {bus.out_tag, bus.out_data}, {5'(got + 1), 32'(got + 1)});
        end
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) bus.in_valid = 1'b0;
      #1;
    end
    bus.in_valid = 1'b0;
    n_vec++;
    if (got !== 4) begin
      n_bad++; $display("FAIL bp_drained: got %0d results want 4", got);
    end
    exp_cnt += 4;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, op_count} !== {1'b0, exp_cnt}) begin
      n_bad++; $display("FAIL bp_count: got %h want %h", {bus.out_valid, op_count},
                        {1'b0, exp_cnt});
    end
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int got = 0;
    int cyc;
    bus.out_ready = 1'b0;
    for (cyc = 0; cyc < 40 && got < 10; cyc++) begin
      @(negedge clk);
      if (cyc == 3) bus.out_ready = 1'b1;
      if (idx < 10) drive(3'b100, 32'(idx * 3), 32'd100, 5'(idx), 1'b1);
      else bus.in_valid = 1'b0;
      #1;
      if (bus.in_valid) begin
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
          n_bad++; $display("FAIL b2b_in_ready_cyc%0d: got %b want 1", cyc, bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_vec++;
        if ({bus.out_tag, bus.out_data} !== {5'(got), 32'(got * 3 + 100)}) begin
          n_bad++; $display("FAIL b2b_result_%0d: got %h want %h", got,
                            {bus.out_tag, bus.out_data}, {5'(got), 32'(got * 3 + 100)});
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    bus.in_valid = 1'b0;
    // Three fill cycles, then one pop per cycle for ten cycles.
    n_vec++;
    if (cyc !== 13 || got !== 10) begin
      n_bad++; $display("FAIL b2b_throughput: got %0d results by cycle %0d want 10 by 13",
                        got, cyc);
    end
    exp_cnt += 10;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, op_count} !== {1'b0, exp_cnt}) begin
      n_bad++; $display("FAIL b2b_count: got %h want %h", {bus.out_valid, op_count},
                        {1'b0, exp_cnt});
    end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'b100, 32'(i), 32'd1, 5'(7 + i), 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
      n_bad++; $display("FAIL ar_loaded: got %b want 10", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.out_valid, bus.in_ready, op_count, bus.out_tag} !== 23'd0) begin
      n_bad++; $display("FAIL ar_immediate: got %h want 0",
                        {bus.out_valid, bus.in_ready, op_count, bus.out_tag});
    end
    exp_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd3, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      n_bad++; $display("FAIL ar_clean: got %b want 10", {bus.in_ready, bus.out_valid});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_vec++;
    if (head() !== {1'b1, 32'h0FF0_0FF0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL ar_first_result: got %h want %h", head(),
                        {1'b1, 32'h0FF0_0FF0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    exp_cnt++;
    @(negedge clk);
    #1;
    n_vec++;
    if ({bus.out_valid, op_count} !== {1'b0, exp_cnt}) begin
      n_bad++; $display("FAIL ar_no_stale: got %h want %h", {bus.out_valid, op_count},
                        {1'b0, exp_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
